// File: rtl/fuzz_stim_sig_engine.sv
`default_nettype none
// ============================================================================
// Module   : fuzz_stim_sig_engine
// Brief    : On-chip fuzz stimulus generator and response compactor. An LFSR
//            produces wide stimulus vectors. Each vector is held for HOLD_CYC
//            clocks. The DUT response is folded into a MISR, which yields one
//            signature per run.
// Revision : 1.0 - initial release
// ============================================================================
module fuzz_stim_sig_engine #(
    parameter int                STIM_W    = 256,
    parameter int                RESP_W    = 350,
    parameter int                CNT_W     = 8,
    parameter int                HOLD_CYC  = 2,
    parameter logic [STIM_W-1:0] LFSR_TAPS = 256'hA42 << 244,
    parameter logic [RESP_W-1:0] MISR_TAPS = RESP_W'(1) | (RESP_W'(1) << (RESP_W - 1))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STIM_W-1:0] seed,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic              zero_ins,
    output logic [STIM_W-1:0] stim,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  vec_idx,
    output logic [RESP_W-1:0] signature
);

    localparam int                  c_HOLD_W    = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYC - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_HOLD_W-1:0] r_hold;
    logic [CNT_W-1:0]    r_num;
    logic [STIM_W-1:0]   r_lfsr;

    logic [STIM_W-1:0]   w_seed_eff;
    logic [STIM_W-1:0]   w_lfsr_step;
    logic [RESP_W-1:0]   w_misr_next;
    logic                w_last_vec;
    logic                w_load;
    logic                w_capture;
    logic                w_advance;
    logic                w_to_gap;
    logic                w_finish;

    // A zero seed would lock the LFSR, so it is replaced by all-ones.
    assign w_seed_eff  = (seed == '0) ? '1 : seed;
    assign w_lfsr_step = {r_lfsr[STIM_W-2:0], ^(r_lfsr & LFSR_TAPS)};
    assign w_misr_next = ({signature[RESP_W-2:0], 1'b0}
                         ^ (signature[RESP_W-1] ? MISR_TAPS : '0)) ^ resp;
    // r_num is nonzero whenever this is consulted, so there is no underflow.
    assign w_last_vec  = (vec_idx == (r_num - CNT_W'(1)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; FIN lasts two cycles so done is high while still in FIN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_vec == '0) ? c_ST_FIN : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (r_hold == c_HOLD_LAST) begin
                    if (w_last_vec) begin
                        w_state_next = c_ST_FIN;
                    end else if (zero_ins) begin
                        w_state_next = c_ST_GAP;
                    end
                end
            end
            c_ST_GAP: w_state_next = c_ST_RUN;
            c_ST_FIN: begin
                if (done) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Output decode: datapath strobes derived from the current state
    always_comb begin
        w_load    = (r_state == c_ST_IDLE) && start;
        w_capture = (r_state == c_ST_RUN) && (r_hold == c_HOLD_LAST);
        w_advance = (w_capture && !w_last_vec && !zero_ins) || (r_state == c_ST_GAP);
        w_to_gap  = w_capture && !w_last_vec && zero_ins;
        w_finish  = w_capture && w_last_vec;
    end

    // Datapath: LFSR, stimulus, hold counter, vector index, MISR and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_idx   <= '0;
            signature <= '0;
            r_hold    <= '0;
            r_lfsr    <= '0;
            r_num     <= '0;
        end else begin
            if (w_load) begin
                signature <= '0;
                vec_idx   <= '0;
                r_num     <= num_vec;
                r_hold    <= '0;
                if (num_vec != '0) begin
                    r_lfsr <= w_seed_eff;
                    stim   <= w_seed_eff;
                    busy   <= 1'b1;
                end
            end
            if ((r_state == c_ST_RUN) && !w_capture) begin
                r_hold <= r_hold + c_HOLD_W'(1);
            end
            if (w_capture) begin
                signature <= w_misr_next;
            end
            if (w_advance) begin
                r_lfsr  <= w_lfsr_step;
                stim    <= w_lfsr_step;
                vec_idx <= vec_idx + CNT_W'(1);
                r_hold  <= '0;
            end
            if (w_to_gap) begin
                stim <= '0;
            end
            if (w_finish) begin
                stim <= '0;
                busy <= 1'b0;
            end
            done <= (r_state == c_ST_FIN) && !done;
        end
    end

endmodule
`default_nettype wire
